uart_csr_host: RTL and testbench

Hardware CSR master for the Milkymist `uart` core: it replaces software or testbench polling of the UART's CSR space. After reset it acknowledges stale events and enables RX/TX interrupts. It then services `uart_irq` by reading and acknowledging `CSR_UART_STAT` and pulling received bytes into an RX FIFO. It also feeds bytes from a valid/ready TX stream into `CSR_UART_RXTX`. It sits directly upstream of the UART CSR port (drives `csr_a/csr_we/csr_di`, consumes `csr_do`) and downstream of any byte producer/consumer.

---
 rtl/uart_csr_host.sv | 168 ++++++++++++++++
 tb/tb_uart_csr_host.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_csr_host.sv
// Hardware CSR master for the Milkymist UART: runs the init/ack sequence,
// drains received bytes into an RX FIFO on uart_irq and feeds a TX byte stream.
module uart_csr_host #(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         RX_DEPTH = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    output logic [13:0]                csr_a,
    output logic                       csr_we,
    output logic [31:0]                csr_do,
    input  logic [31:0]                csr_di,
    input  logic                       uart_irq,
    input  logic                       tx_valid,
    input  logic [7:0]                 tx_data,
    output logic                       tx_ready,
    output logic                       rx_valid,
    output logic [7:0]                 rx_data,
    input  logic                       rx_ready,
    output logic [$clog2(RX_DEPTH):0]  rx_level,
    output logic                       rx_overflow,
    input  logic                       ovf_clr
);
    localparam int          PW         = $clog2(RX_DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(RX_DEPTH);
    localparam logic [9:0]  REG_RXTX   = 10'h000;
    localparam logic [9:0]  REG_STAT   = 10'h002;
    localparam logic [9:0]  REG_CTRL   = 10'h003;

    typedef enum logic [3:0] {
        INIT_RA, INIT_RC, INIT_ACK, INIT_CTRL, IDLE,
        STAT_RA, STAT_RC, ACK, RX_RA, RX_RC, TX_W, WAIT
    } state_t;

    state_t      state, state_next;
    logic [31:0] stat;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        access;
    logic [9:0]  reg_sel;
    logic [13:0] last_a;

    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    logic          push, pop, push_ok;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= INIT_RA;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT_RA:   state_next = INIT_RC;
            INIT_RC:   state_next = INIT_ACK;
            INIT_ACK:  state_next = INIT_CTRL;
            INIT_CTRL: state_next = IDLE;
            IDLE: begin
                if (uart_irq)                 state_next = STAT_RA;
                else if (tx_valid && !tx_busy) state_next = TX_W;
            end
            STAT_RA:   state_next = STAT_RC;
            STAT_RC:   state_next = ACK;
            ACK:       state_next = stat[1] ? RX_RA : WAIT;
            RX_RA:     state_next = RX_RC;
            RX_RC:     state_next = WAIT;
            TX_W:      state_next = WAIT;
            WAIT:      state_next = IDLE;
            default:   state_next = INIT_RA;
        endcase
    end

    // Outputs are decoded from state so an async reset kills a write at once.
    always_comb begin
        access  = 1'b0;
        reg_sel = REG_STAT;
        csr_we  = 1'b0;
        csr_do  = 32'h0;
        case (state)
            INIT_RA, INIT_RC, STAT_RA, STAT_RC: begin
                access  = 1'b1;
                reg_sel = REG_STAT;
            end
            INIT_ACK, ACK: begin
                access  = 1'b1;
                reg_sel = REG_STAT;
                csr_we  = 1'b1;
                csr_do  = stat;
            end
            INIT_CTRL: begin
                access  = 1'b1;
                reg_sel = REG_CTRL;
                csr_we  = 1'b1;
                csr_do  = 32'h3;
            end
            RX_RA, RX_RC: begin
                access  = 1'b1;
                reg_sel = REG_RXTX;
            end
            TX_W: begin
                access  = 1'b1;
                reg_sel = REG_RXTX;
                csr_we  = 1'b1;
                csr_do  = {24'h0, tx_byte};
            end
            default: ;
        endcase
    end

    assign csr_a    = access ? {csr_addr, reg_sel} : last_a;
    assign tx_ready = (state == IDLE) && !uart_irq && !tx_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_a  <= {csr_addr, REG_STAT};
            stat    <= 32'h0;
            tx_byte <= 8'h00;
            tx_busy <= 1'b0;
        end else begin
            last_a <= csr_a;
            if (state == INIT_RC || state == STAT_RC)
                stat <= csr_di;
            if (tx_valid && tx_ready)
                tx_byte <= tx_data;
            // A TX_EVT ack frees the transmitter for the next byte.
            if (state == TX_W)
                tx_busy <= 1'b1;
            else if (state == ACK && stat[2])
                tx_busy <= 1'b0;
        end
    end

    assign push    = (state == RX_RC);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push && ((level < FULL_LEVEL) || pop);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rx_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push && !push_ok) rx_overflow <= 1'b1;
            else if (ovf_clr)     rx_overflow <= 1'b0;
        end
    end

    // When full with a coincident pop, wr_ptr equals rd_ptr, so the new byte
    // lands in the slot being vacated and becomes the newest entry.
    always_ff @(posedge sys_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= csr_di[7:0];
    end

    assign rx_valid = (level != '0);
    assign rx_data  = rx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign rx_level = level;

endmodule

// File: tb/tb_uart_csr_host.sv
// Directed bench for uart_csr_host with a small Milkymist UART CSR model
// (write-1-to-clear STAT, CTRL enables, delayed TX_EVT) and loopback printer.
module tb_uart_csr_host;
    localparam logic [3:0]  BANK     = 4'hA;
    localparam int          DEPTH    = 16;
    localparam int          TX_DELAY = 4;
    localparam logic [13:0] A_RXTX   = 14'h2800;
    localparam logic [13:0] A_STAT   = 14'h2802;
    localparam logic [13:0] A_CTRL   = 14'h2803;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_do;
    logic [31:0] m_di = 32'h0;
    logic        uart_irq;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready = 1'b0;
    logic [4:0]  rx_level;
    logic        rx_overflow;
    logic        ovf_clr = 1'b0;

    logic [31:0] m_stat = 32'h0;
    logic [31:0] m_stat_next;
    logic [31:0] m_ctrl = 32'h0;
    logic [7:0]  m_rxbuf = 8'h00;
    int          tx_cnt = 0;
    logic        inj_rx = 1'b0;
    logic [7:0]  inj_byte = 8'h00;
    logic        preset = 1'b0;
    logic [31:0] preset_val = 32'h0;
    logic [7:0]  tx_log [$];
    logic        bus_hit;

    int check_count = 0;
    int pass_count  = 0;

    uart_csr_host #(.csr_addr(BANK), .RX_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .csr_a(csr_a), .csr_we(csr_we), .csr_do(csr_do), .csr_di(m_di),
        .uart_irq(uart_irq),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_level(rx_level), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr)
    );

    always #5 sys_clk = ~sys_clk;

    // UART model: STAT is write-1-to-clear, TX_EVT rises TX_DELAY cycles after an RXTX write.
    assign bus_hit  = (csr_a[13:10] == BANK);
    assign uart_irq = (m_stat[1] & m_ctrl[0]) | (m_stat[2] & m_ctrl[1]);

    always_comb begin
        m_stat_next = m_stat;
        if (bus_hit && csr_we && csr_a[9:0] == 10'h002) m_stat_next = m_stat_next & ~csr_do;
        if (tx_cnt == 1) m_stat_next[2] = 1'b1;
        if (inj_rx)      m_stat_next[1] = 1'b1;
        if (preset)      m_stat_next = preset_val;
    end

    always @(posedge sys_clk) begin
        m_stat <= m_stat_next;
        if (!bus_hit) m_di <= 32'h0;
        else case (csr_a[9:0])
            10'h000: m_di <= {24'h0, m_rxbuf};
            10'h002: m_di <= m_stat;
            10'h003: m_di <= m_ctrl;
            default: m_di <= 32'h0;
        endcase
        if (bus_hit && csr_we && csr_a[9:0] == 10'h000) begin
            tx_log.push_back(csr_do[7:0]);
            $display("[TB] loopback partner received 0x%02h", csr_do[7:0]);
            tx_cnt <= TX_DELAY;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        if (bus_hit && csr_we && csr_a[9:0] == 10'h003) m_ctrl <= csr_do;
        if (inj_rx) m_rxbuf <= inj_byte;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic txv, input logic [7:0] txd, input logic rxr, input logic clr);
        tx_valid = txv;
        tx_data  = txd;
        rx_ready = rxr;
        ovf_clr  = clr;
    endtask

    task automatic tick;
        @(negedge sys_clk);
    endtask

    // Leaves the bench in the cycle where IDLE first sees uart_irq high.
    task automatic injectRx(input logic [7:0] b);
        inj_byte = b;
        inj_rx   = 1'b1;
        tick();
        inj_rx   = 1'b0;
    endtask

    task automatic receiveByte(input logic [7:0] b);
        injectRx(b);
        repeat (7) tick();
    endtask

    // Called on a negedge while in reset with the model STAT preset to 0x6.
    task automatic checkInitSequence(input string pfx);
        sys_rst_n = 1'b1;
        #1;
        checkOutput({pfx, "_c0_we"}, csr_we, 0);
        checkOutput({pfx, "_c0_a"}, csr_a, A_STAT);
        tick();
        checkOutput({pfx, "_c1_we"}, csr_we, 0);
        checkOutput({pfx, "_c1_a"}, csr_a, A_STAT);
        tick();
        checkOutput({pfx, "_c2_we"}, csr_we, 1);
        checkOutput({pfx, "_c2_a"}, csr_a, A_STAT);
        checkOutput({pfx, "_c2_do"}, csr_do, 32'h6);
        tick();
        checkOutput({pfx, "_c3_we"}, csr_we, 1);
        checkOutput({pfx, "_c3_a"}, csr_a, A_CTRL);
        checkOutput({pfx, "_c3_do"}, csr_do, 32'h3);
        tick();
        checkOutput({pfx, "_c4_tx_ready"}, tx_ready, 1);
        checkOutput({pfx, "_c4_we"}, csr_we, 0);
        checkOutput({pfx, "_c4_a_hold"}, csr_a, A_CTRL);
        checkOutput({pfx, "_c4_do"}, csr_do, 0);
    endtask

    initial begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        preset_val = 32'h6;
        preset     = 1'b1;
        tick();
        preset = 1'b0;
        tick();

        checkOutput("rst_csr_a", csr_a, A_STAT);
        checkOutput("rst_csr_we", csr_we, 0);
        checkOutput("rst_csr_do", csr_do, 0);
        checkOutput("rst_tx_ready", tx_ready, 0);
        checkOutput("rst_rx_valid", rx_valid, 0);
        checkOutput("rst_rx_data", rx_data, 0);
        checkOutput("rst_rx_level", rx_level, 0);
        checkOutput("rst_rx_overflow", rx_overflow, 0);

        checkInitSequence("init");

        // Single RX byte: ack of 0x2, RXTX read, byte visible in cycle 6.
        injectRx(8'h41);
        checkOutput("rx_c0_tx_ready", tx_ready, 0);
        tick();
        checkOutput("rx_c1_a", csr_a, A_STAT);
        checkOutput("rx_c1_we", csr_we, 0);
        tick();
        tick();
        checkOutput("rx_c3_we", csr_we, 1);
        checkOutput("rx_c3_a", csr_a, A_STAT);
        checkOutput("rx_c3_do", csr_do, 32'h2);
        tick();
        checkOutput("rx_c4_a", csr_a, A_RXTX);
        checkOutput("rx_c4_we", csr_we, 0);
        tick();
        checkOutput("rx_c5_valid", rx_valid, 0);
        tick();
        checkOutput("rx_c6_valid", rx_valid, 1);
        checkOutput("rx_c6_data", rx_data, 8'h41);
        checkOutput("rx_c6_level", rx_level, 1);
        tick();
        checkOutput("rx_c7_tx_ready", tx_ready, 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rx_pop_level", rx_level, 0);
        checkOutput("rx_pop_valid", rx_valid, 0);

        // TX stream: 0x55 then 0xAA, gated by the TX_EVT ack.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        #1;
        checkOutput("tx_c0_ready", tx_ready, 1);
        tick();
        checkOutput("tx_c1_we", csr_we, 1);
        checkOutput("tx_c1_a", csr_a, A_RXTX);
        checkOutput("tx_c1_do", csr_do, 32'h55);
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int c = 2; c <= 10; c++) begin
            tick();
            checkOutput("tx_busy_ready", tx_ready, 0);
            if (c == 9) begin
                checkOutput("tx_ack_we", csr_we, 1);
                checkOutput("tx_ack_a", csr_a, A_STAT);
                checkOutput("tx_ack_do", csr_do, 32'h4);
            end
        end
        tick();
        checkOutput("tx_c11_ready", tx_ready, 1);
        tick();
        checkOutput("tx_c12_we", csr_we, 1);
        checkOutput("tx_c12_a", csr_a, A_RXTX);
        checkOutput("tx_c12_do", csr_do, 32'hAA);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (15) tick();
        checkOutput("tx_done_ready", tx_ready, 1);
        checkOutput("tx_log_size", tx_log.size(), 2);
        if (tx_log.size() >= 2) begin
            checkOutput("tx_log_0", tx_log[0], 8'h55);
            checkOutput("tx_log_1", tx_log[1], 8'hAA);
        end

        // Overflow: 17 bytes into a 16-deep FIFO with no pops.
        for (int i = 0; i < 17; i++) receiveByte(8'(8'h10 + i));
        checkOutput("ovf_level", rx_level, 16);
        checkOutput("ovf_flag", rx_overflow, 1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("ovf_pop_data", rx_data, 8'(8'h10 + i));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_drained_level", rx_level, 0);
        checkOutput("ovf_sticky", rx_overflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ovf_cleared", rx_overflow, 0);

        // Full FIFO: push coincides with pop in RX_RC.
        for (int i = 0; i < 16; i++) receiveByte(8'(8'h30 + i));
        checkOutput("full_level", rx_level, 16);
        injectRx(8'h40);
        repeat (5) tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_pp_level", rx_level, 16);
        checkOutput("full_pp_overflow", rx_overflow, 0);
        checkOutput("full_pp_head", rx_data, 8'h31);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("full_pop_data", rx_data, 8'(8'h31 + i));
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("full_drained_level", rx_level, 0);

        // Reset asserted in the middle of an ACK write.
        receiveByte(8'h77);
        checkOutput("mid_pre_level", rx_level, 1);
        injectRx(8'h78);
        repeat (3) tick();
        checkOutput("mid_ack_we", csr_we, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_we", csr_we, 0);
        checkOutput("mid_rst_level", rx_level, 0);
        checkOutput("mid_rst_valid", rx_valid, 0);
        checkOutput("mid_rst_a", csr_a, A_STAT);
        tick();
        preset_val = 32'h6;
        preset     = 1'b1;
        tick();
        preset = 1'b0;
        tick();
        checkInitSequence("reinit");
        repeat (3) tick();
        checkOutput("reinit_level", rx_level, 0);
        checkOutput("reinit_tx_ready", tx_ready, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
